// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core. It produces execute-stage forward selects,
// load-use stalls, branch flushes, a pipeline freeze on dmem wait, and stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic lduse, memwait, freeze;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign lduse   = ResultSrcE && RD_E != 5'd0 && (RD_E == Rs1D || RD_E == Rs2D);
  assign memwait = dmem_req_M && !dmem_ready;
  assign freeze  = memwait || state_q == ERR;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RD_M, RegWriteW, RD_W);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RD_M, RegWriteW, RD_W);
      // A frozen execute stage keeps any taken branch until the freeze lifts.
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (memwait) begin
          state_d    = WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (!memwait) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (PCSrcE && !freeze && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = (state_q == ERR);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl, built with TIMEOUT=4 and CNT_W=3 so that
// the timeout and counter saturation are reached in a few cycles.
module tb_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
  logic ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_req_M, dmem_ready, cnt_clr;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    dmem_req_M = 0; dmem_ready = 0; cnt_clr = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    RegWriteM = 1; RD_M = 5; Rs1E = 5;
    PCSrcE = 1; ResultSrcE = 1; RD_E = 7; Rs1D = 7;
    #3;
    chk("rst_fwdA", 32'(ForwardAE), 32'd0);
    chk("rst_stallF", 32'(StallF), 32'd0);
    chk("rst_stallM", 32'(StallM), 32'd0);
    chk("rst_flushD", 32'(FlushD), 32'd1);
    chk("rst_flushE", 32'(FlushE), 32'd1);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    clear_inputs();
    rst = 1'b0;

    // T1 forwarding
    RegWriteM = 1; RD_M = 5; Rs1E = 5; Rs2E = 5; RegWriteW = 1; RD_W = 5;
    #1;
    chk("t1_fwdA_mem", 32'(ForwardAE), 32'd2);
    chk("t1_fwdB_mem", 32'(ForwardBE), 32'd2);
    chk("t1_flushD", 32'(FlushD), 32'd0);
    RD_M = 0;
    #1;
    chk("t1_fwdA_wb", 32'(ForwardAE), 32'd1);
    Rs1E = 0; RD_W = 0;
    #1;
    chk("t1_fwdA_x0", 32'(ForwardAE), 32'd0);
    RD_W = 5; RegWriteW = 0;
    #1;
    chk("t1_fwdB_nowr", 32'(ForwardBE), 32'd0);
    clear_inputs();
    tick();

    // T2 load-use
    ResultSrcE = 1; RD_E = 7; Rs2D = 7;
    #1;
    chk("t2_stallF", 32'(StallF), 32'd1);
    chk("t2_stallD", 32'(StallD), 32'd1);
    chk("t2_flushE", 32'(FlushE), 32'd1);
    chk("t2_flushD", 32'(FlushD), 32'd0);
    chk("t2_stallE", 32'(StallE), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("t2_stallF_off", 32'(StallF), 32'd0);
    RD_E = 0; ResultSrcE = 1; Rs1D = 0;
    #1;
    chk("t2_x0_nostall", 32'(StallF), 32'd0);
    clear_inputs();

    // T3 branch beats load-use
    PCSrcE = 1; ResultSrcE = 1; RD_E = 7; Rs1D = 7;
    #1;
    chk("t3_flushD", 32'(FlushD), 32'd1);
    chk("t3_flushE", 32'(FlushE), 32'd1);
    chk("t3_stallF", 32'(StallF), 32'd0);
    chk("t3_stallD", 32'(StallD), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("t3_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);

    // T4 three dmem wait cycles, with a branch held in the frozen pipe
    dmem_req_M = 1; dmem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stallM", 32'(StallM), 32'd1);
      chk("t4_stallF", 32'(StallF), 32'd1);
      chk("t4_flushD", 32'(FlushD), 32'd0);
      tick();
    end
    PCSrcE = 0; dmem_ready = 1;
    #1;
    chk("t4_ready_stallF", 32'(StallF), 32'd0);
    chk("t4_timeout", 32'(mem_timeout), 32'd0);
    tick();
    #1;
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd4);
    chk("t4_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("t4_same_cycle_ready", 32'(StallE), 32'd0);
    clear_inputs();
    tick();

    // T5 timeout; the three-cycle wait above must have left the FSM in IDLE
    dmem_req_M = 1; dmem_ready = 0;
    tick(); tick(); tick();
    chk("t5_not_yet", 32'(mem_timeout), 32'd0);
    tick();
    chk("t5_timeout", 32'(mem_timeout), 32'd1);
    dmem_ready = 1;
    tick();
    chk("t5_sticky", 32'(mem_timeout), 32'd1);
    chk("t5_err_freeze", 32'(StallF), 32'd1);
    chk("t5_stall_sat", 32'(stall_cnt), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_timeout", 32'(mem_timeout), 32'd0);
    chk("t5_rst_stallF", 32'(StallF), 32'd0);
    chk("t5_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("t5_post_rst_stall", 32'(StallF), 32'd0);

    // T6 saturation and clear
    ResultSrcE = 1; RD_E = 3; Rs1D = 3;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_sat", 32'(stall_cnt), 32'd7);
    PCSrcE = 1;
    ResultSrcE = 0;
    tick();
    chk("t6_flush_cnt", 32'(flush_cnt), 32'd1);
    PCSrcE = 0; ResultSrcE = 1; cnt_clr = 1;
    tick();
    chk("t6_clr_stall", 32'(stall_cnt), 32'd0);
    chk("t6_clr_flush", 32'(flush_cnt), 32'd0);
    cnt_clr = 0;
    tick();
    chk("t6_resume", 32'(stall_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
